id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RISC-V core, with load-use and JALR-after-load hazard detection.
- Captures decoded fields from ID and drives the ID_EX_* signals that the downstream forwarding unit and EX stage consume (RS1/RS2 addresses, RD, MEM_WRITE, REG_WRITE, MEM_READ).
- Inserts bubbles and raises a stall to IF/ID when forwarding alone cannot resolve a hazard.
- Owns a small FSM for the extra stall cycle that a JALR needs when it depends on a load.

---
 rtl/core_pkg.sv | 22 ++
 rtl/id_ex_stage_hazard_detect.sv | 39 +++
 rtl/id_ex_stage.sv | 173 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the ID/EX stage: field widths, JALR wait FSM state, control bubble.
// No logic of its own; imported by id_ex_stage and hazard_detect.
package core_pkg;

    localparam int ALU_OP_W   = 4;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        JW1  = 1'b1
    } jw_state_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Purpose: combinational load-use and JALR-after-load hazard detection for the ID stage.
// Latency: zero (pure combinational).
// Backpressure: none; consumers gate the result with flush/freeze.
module hazard_detect
    import core_pkg::*;
(
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_mem_write,
    input  logic                  id_is_jalr,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_mem_read,
    output logic                  load_use,
    output logic                  jalr_two,
    output logic                  jalr_hazard
);

    logic rs1_hit;
    logic rs2_hit;
    logic jalr_chk;
    logic jalr_one;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    // rs2 of a store is served by MEM-stage store-data forwarding
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd) && !id_mem_write;

    assign load_use = id_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

    assign jalr_chk    = id_valid && id_is_jalr && (id_rs1 != '0);
    assign jalr_two    = jalr_chk && ex_mem_read  && (id_rs1 == ex_rd);
    assign jalr_one    = jalr_chk && mem_mem_read && (id_rs1 == mem_rd);
    assign jalr_hazard = jalr_two || jalr_one;

endmodule

// File: rtl/id_ex_stage.sv
// Purpose: ID/EX pipeline register with load-use / JALR hazard bubbles; optional ID_EX_HAZARD_STAT_EN counters.
// Latency: one cycle ID -> ID_EX_*; stall_o is combinational in the ID cycle.
// Backpressure: stall_o holds IF/ID; ext_stall_i freezes this stage; flush_i overrides both.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst_n,
    input  logic                  id_valid,
    input  logic [PC_W-1:0]       id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [DATA_W-1:0]     id_rd1,
    input  logic [DATA_W-1:0]     id_rd2,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [ALU_OP_W-1:0]   id_alu_op,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_is_jalr,
    input  logic [REG_ADDR_W-1:0] EX_MEM_RD,
    input  logic                  EX_MEM_MEM_READ,
    input  logic                  flush_i,
    input  logic                  ext_stall_i,
    output logic                  stall_o,
    output logic                  ID_EX_VALID,
    output logic [PC_W-1:0]       ID_EX_PC,
    output logic [REG_ADDR_W-1:0] ID_EX_RS1_ADDR,
    output logic [REG_ADDR_W-1:0] ID_EX_RS2_ADDR,
    output logic [REG_ADDR_W-1:0] ID_EX_RD,
    output logic [DATA_W-1:0]     ID_EX_RD1,
    output logic [DATA_W-1:0]     ID_EX_RD2,
    output logic [DATA_W-1:0]     ID_EX_IMM,
    output logic [ALU_OP_W-1:0]   ID_EX_ALU_OP,
    output logic                  ID_EX_REG_WRITE,
    output logic                  ID_EX_MEM_READ,
    output logic                  ID_EX_MEM_WRITE
`ifdef ID_EX_HAZARD_STAT_EN
    ,
    output logic [31:0]           stat_lu_cnt,
    output logic [31:0]           stat_jalr_cnt,
    output logic [31:0]           stat_flush_cnt
`endif
);

    ctrl_t                 ctrl_q;
    logic [PC_W-1:0]       pc_q;
    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic [DATA_W-1:0]     rd1_q, rd2_q, imm_q;
    logic [ALU_OP_W-1:0]   alu_op_q;
    jw_state_t             state_q, state_d;

    logic load_use, jalr_two, jalr_hazard;
    logic load_bubble;
    logic advance;

    hazard_detect u_hazard_detect (
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_mem_write (id_mem_write),
        .id_is_jalr   (id_is_jalr),
        .ex_rd        (rd_q),
        .ex_mem_read  (ctrl_q.mem_read),
        .mem_rd       (EX_MEM_RD),
        .mem_mem_read (EX_MEM_MEM_READ),
        .load_use     (load_use),
        .jalr_two     (jalr_two),
        .jalr_hazard  (jalr_hazard)
    );

    assign stall_o     = !flush_i && (load_use || jalr_hazard || (state_q == JW1));
    assign advance     = !flush_i && !ext_stall_i;
    assign load_bubble = flush_i || (!ext_stall_i && stall_o);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            ctrl_q   <= CTRL_BUBBLE;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            alu_op_q <= '0;
        end else if (load_bubble) begin
            ctrl_q   <= CTRL_BUBBLE;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            alu_op_q <= '0;
        end else if (!ext_stall_i) begin
            // an invalid slot still carries its fields but never writes or touches memory
            ctrl_q   <= id_valid ? ctrl_t'{1'b1, id_reg_write, id_mem_read, id_mem_write} : CTRL_BUBBLE;
            pc_q     <= id_pc;
            rs1_q    <= id_rs1;
            rs2_q    <= id_rs2;
            rd_q     <= id_rd;
            rd1_q    <= id_rd1;
            rd2_q    <= id_rd2;
            imm_q    <= id_imm;
            alu_op_q <= id_alu_op;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (advance) begin
            case (state_q)
                IDLE:    if (jalr_two) state_d = JW1;
                JW1:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign ID_EX_VALID     = ctrl_q.valid;
    assign ID_EX_REG_WRITE = ctrl_q.reg_write;
    assign ID_EX_MEM_READ  = ctrl_q.mem_read;
    assign ID_EX_MEM_WRITE = ctrl_q.mem_write;
    assign ID_EX_PC        = pc_q;
    assign ID_EX_RS1_ADDR  = rs1_q;
    assign ID_EX_RS2_ADDR  = rs2_q;
    assign ID_EX_RD        = rd_q;
    assign ID_EX_RD1       = rd1_q;
    assign ID_EX_RD2       = rd2_q;
    assign ID_EX_IMM       = imm_q;
    assign ID_EX_ALU_OP    = alu_op_q;

`ifdef ID_EX_HAZARD_STAT_EN
    logic [31:0] lu_cnt_q, jalr_cnt_q, flush_cnt_q;

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            lu_cnt_q    <= '0;
            jalr_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else if (!ext_stall_i) begin
            if (!flush_i && load_use && (lu_cnt_q != '1))
                lu_cnt_q <= lu_cnt_q + 32'd1;
            if (!flush_i && (jalr_hazard || (state_q == JW1)) && (jalr_cnt_q != '1))
                jalr_cnt_q <= jalr_cnt_q + 32'd1;
            if (flush_i && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stat_lu_cnt    = lu_cnt_q;
    assign stat_jalr_cnt  = jalr_cnt_q;
    assign stat_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by randomized traffic
// compared against a behavioural model of the ID/EX register and its stall rules.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    logic              cpu_clk = 1'b0;
    logic              cpu_rst_n;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2;
    logic [DATA_W-1:0] id_rd1, id_rd2, id_imm;
    logic [3:0]        id_alu_op;
    logic              id_reg_write, id_mem_read, id_mem_write, id_is_jalr;
    logic [4:0]        ex_mem_rd;
    logic              ex_mem_mem_read;
    logic              flush_i, ext_stall_i;
    logic              stall_o;
    logic              ID_EX_VALID;
    logic [PC_W-1:0]   ID_EX_PC;
    logic [4:0]        ID_EX_RS1_ADDR, ID_EX_RS2_ADDR, ID_EX_RD;
    logic [DATA_W-1:0] ID_EX_RD1, ID_EX_RD2, ID_EX_IMM;
    logic [3:0]        ID_EX_ALU_OP;
    logic              ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE;

    always #5 cpu_clk = ~cpu_clk;

    id_ex_stage #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .cpu_clk         (cpu_clk),
        .cpu_rst_n       (cpu_rst_n),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd1          (id_rd1),
        .id_rd2          (id_rd2),
        .id_imm          (id_imm),
        .id_alu_op       (id_alu_op),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .id_is_jalr      (id_is_jalr),
        .EX_MEM_RD       (ex_mem_rd),
        .EX_MEM_MEM_READ (ex_mem_mem_read),
        .flush_i         (flush_i),
        .ext_stall_i     (ext_stall_i),
        .stall_o         (stall_o),
        .ID_EX_VALID     (ID_EX_VALID),
        .ID_EX_PC        (ID_EX_PC),
        .ID_EX_RS1_ADDR  (ID_EX_RS1_ADDR),
        .ID_EX_RS2_ADDR  (ID_EX_RS2_ADDR),
        .ID_EX_RD        (ID_EX_RD),
        .ID_EX_RD1       (ID_EX_RD1),
        .ID_EX_RD2       (ID_EX_RD2),
        .ID_EX_IMM       (ID_EX_IMM),
        .ID_EX_ALU_OP    (ID_EX_ALU_OP),
        .ID_EX_REG_WRITE (ID_EX_REG_WRITE),
        .ID_EX_MEM_READ  (ID_EX_MEM_READ),
        .ID_EX_MEM_WRITE (ID_EX_MEM_WRITE)
    );

    // Model of what sits in EX, plus the number of extra JALR wait cycles still owed.
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm;
        logic [3:0]  alu;
        logic        rw, mr, mw;
    } ex_t;

    ex_t m;
    int  owed_waits;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  stall_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_zero();
        m.valid = 0; m.pc = 0; m.rs1 = 0; m.rs2 = 0; m.rd = 0;
        m.rd1 = 0; m.rd2 = 0; m.imm = 0; m.alu = 0; m.rw = 0; m.mr = 0; m.mw = 0;
    endtask

    function automatic bit jalr_on_ex_load();
        return id_valid && id_is_jalr && id_rs1 != 0 && m.mr && id_rs1 == m.rd;
    endfunction

    function automatic bit exp_stall();
        bit lu, jl;
        lu = id_valid && m.mr && m.rd != 0 &&
             ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd && !id_mem_write));
        jl = jalr_on_ex_load() ||
             (id_valid && id_is_jalr && id_rs1 != 0 && ex_mem_mem_read && id_rs1 == ex_mem_rd);
        return !flush_i && (lu || jl || owed_waits > 0);
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".valid"}, ID_EX_VALID,     m.valid);
        check({tag, ".pc"},    ID_EX_PC,        m.pc);
        check({tag, ".rs1"},   ID_EX_RS1_ADDR,  m.rs1);
        check({tag, ".rs2"},   ID_EX_RS2_ADDR,  m.rs2);
        check({tag, ".rd"},    ID_EX_RD,        m.rd);
        check({tag, ".rd1"},   ID_EX_RD1,       m.rd1);
        check({tag, ".rd2"},   ID_EX_RD2,       m.rd2);
        check({tag, ".imm"},   ID_EX_IMM,       m.imm);
        check({tag, ".alu"},   ID_EX_ALU_OP,    m.alu);
        check({tag, ".ctrl"}, {ID_EX_REG_WRITE, ID_EX_MEM_READ, ID_EX_MEM_WRITE}, {m.rw, m.mr, m.mw});
    endtask

    // Inputs must already be applied; checks stall_o, clocks once, then checks the register.
    task automatic step(input string tag);
        bit s, j2;
        #1;
        s  = exp_stall();
        j2 = jalr_on_ex_load();
        check({tag, ".stall"}, stall_o, s);
        if (stall_o) stall_cnt++;
        @(posedge cpu_clk);
        if (flush_i) begin
            model_zero();
            owed_waits = 0;
        end else if (!ext_stall_i) begin
            if (s) begin
                model_zero();
                owed_waits = (owed_waits > 0) ? owed_waits - 1 : (j2 ? 1 : 0);
            end else begin
                m.valid = id_valid; m.pc = id_pc; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
                m.rd1 = id_rd1; m.rd2 = id_rd2; m.imm = id_imm; m.alu = id_alu_op;
                m.rw = id_valid && id_reg_write;
                m.mr = id_valid && id_mem_read;
                m.mw = id_valid && id_mem_write;
            end
        end
        #1;
        check_regs(tag);
    endtask

    task automatic id_nop();
        id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_alu_op = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_is_jalr = 0;
        ex_mem_rd = 0; ex_mem_mem_read = 0; flush_i = 0; ext_stall_i = 0;
    endtask

    task automatic id_set(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input bit u1, input bit u2, input bit rw,
                          input bit mr, input bit mw, input bit jalr);
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = mw; id_is_jalr = jalr;
        id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom; id_alu_op = 4'($urandom_range(0, 15));
    endtask

    initial begin
        model_zero();
        owed_waits = 0;
        id_nop();
        cpu_rst_n = 0;
        #12;
        check_regs("reset");
        check("reset.stall", stall_o, 0);
        @(negedge cpu_clk);
        cpu_rst_n = 1;

        // load-use: lw x5 then add x6,x5,x1
        id_set(32'h40, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0);
        step("lw5");
        id_set(32'h44, 5'd5, 5'd1, 5'd6, 1, 1, 1, 0, 0, 0);
        #1 check("lu.stall_now", stall_o, 1);
        step("lu1");
        check("lu.bubble_valid", ID_EX_VALID, 0);
        check("lu.bubble_rd", ID_EX_RD, 0);
        step("lu2");
        check("lu.captured_rd", ID_EX_RD, 6);

        // store data exemption: lw x5 then sw x5,0(x2)
        id_set(32'h48, 5'd2, 5'd0, 5'd5, 1, 0, 1, 1, 0, 0);
        step("lw5b");
        id_set(32'h4c, 5'd2, 5'd5, 5'd0, 1, 1, 0, 0, 1, 0);
        #1 check("st.no_stall", stall_o, 0);
        step("st");
        check("st.rs2", ID_EX_RS2_ADDR, 5);

        // JALR after load: two stall cycles, captured on the third edge
        id_set(32'h50, 5'd2, 5'd0, 5'd1, 1, 0, 1, 1, 0, 0);
        step("lw1");
        id_set(32'h54, 5'd1, 5'd0, 5'd0, 1, 0, 1, 0, 0, 1);
        stall_cnt = 0;
        step("jalr1");
        ex_mem_rd = 5'd1; ex_mem_mem_read = 1;
        step("jalr2");
        ex_mem_rd = 5'd0; ex_mem_mem_read = 0;
        step("jalr3");
        check("jalr.stall_cycles", stall_cnt, 2);
        check("jalr.captured_pc", ID_EX_PC, 32'h54);

        // flush beats load-use
        id_set(32'h60, 5'd2, 5'd0, 5'd7, 1, 0, 1, 1, 0, 0);
        step("lw7");
        id_set(32'h64, 5'd7, 5'd0, 5'd8, 1, 0, 1, 0, 0, 0);
        flush_i = 1;
        #1 check("flush.stall", stall_o, 0);
        step("flush");
        check("flush.valid", ID_EX_VALID, 0);
        flush_i = 0;
        id_nop();
        step("post_flush");

        // freeze with PC 0x100 in EX
        id_set(32'h100, 5'd3, 5'd4, 5'd9, 1, 1, 1, 0, 0, 0);
        step("pc100");
        id_set(32'h104, 5'd1, 5'd2, 5'd10, 1, 1, 1, 0, 0, 0);
        ext_stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step("freeze");
            check("freeze.pc", ID_EX_PC, 32'h100);
        end
        ext_stall_i = 0;
        step("unfreeze");

        // freeze while in JW1, then the remaining wait cycle still applies
        id_set(32'h110, 5'd2, 5'd0, 5'd3, 1, 0, 1, 1, 0, 0);
        step("lw3");
        id_set(32'h114, 5'd3, 5'd0, 5'd1, 1, 0, 1, 0, 0, 1);
        step("jw_enter");
        ext_stall_i = 1;
        for (int i = 0; i < 3; i++) step("jw_freeze");
        ext_stall_i = 0;
        #1 check("jw_held.stall", stall_o, 1);
        step("jw_leave");
        step("jw_capture");
        check("jw.captured_pc", ID_EX_PC, 32'h114);

        // async reset in the middle of JW1
        id_set(32'h120, 5'd2, 5'd0, 5'd4, 1, 0, 1, 1, 0, 0);
        step("lw4");
        id_set(32'h124, 5'd4, 5'd0, 5'd1, 1, 0, 1, 0, 0, 1);
        step("jw_enter2");
        id_nop();
        #2 cpu_rst_n = 0;
        model_zero();
        owed_waits = 0;
        #1;
        check_regs("async_rst");
        @(negedge cpu_clk);
        cpu_rst_n = 1;
        #1 check("rst_release.stall", stall_o, 0);
        step("after_rst");

        // randomized traffic over a small register space so hazards are frequent
        for (int i = 0; i < 600; i++) begin
            id_valid        = ($urandom_range(0, 9) != 0);
            id_pc           = $urandom;
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            id_rd           = 5'($urandom_range(0, 3));
            id_use_rs1      = $urandom_range(0, 1);
            id_use_rs2      = $urandom_range(0, 1);
            id_rd1          = $urandom;
            id_rd2          = $urandom;
            id_imm          = $urandom;
            id_alu_op       = 4'($urandom_range(0, 15));
            id_reg_write    = $urandom_range(0, 1);
            id_mem_read     = ($urandom_range(0, 2) == 0);
            id_mem_write    = ($urandom_range(0, 3) == 0);
            id_is_jalr      = ($urandom_range(0, 3) == 0);
            ex_mem_rd       = 5'($urandom_range(0, 3));
            ex_mem_mem_read = $urandom_range(0, 1);
            flush_i         = ($urandom_range(0, 9) == 0);
            ext_stall_i     = ($urandom_range(0, 7) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
